// File: rtl/pcpu_run_ctrl.sv
// Run controller for PCPU: sequences cpu reset/start/enable, counts run cycles, stops on HALT,
// abort or timeout, and keeps a PC trace FIFO. Define RUN_CTRL_STEP_EN to add single-step control.
module pcpu_run_ctrl #(
  parameter int         ADDR_W      = 8,
  parameter int         DATA_W      = 16,
  parameter logic [4:0] HALT_OPCODE = 5'b00001,
  parameter int         RST_CYCLES  = 2,
  parameter int         CNT_W       = 16,
  parameter int         TIMEOUT     = 1024,
  parameter int         TRACE_DEPTH = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              go_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] cpu_pc_i,
  input  logic [DATA_W-1:0] cpu_id_ir_i,
`ifdef RUN_CTRL_STEP_EN
  input  logic              step_mode_i,
  input  logic              step_i,
`endif
  output logic              cpu_reset_o,
  output logic              cpu_start_o,
  output logic              cpu_enable_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  input  logic              trace_rd_i,
  output logic [ADDR_W-1:0] trace_data_o,
  output logic              trace_valid_o,
  output logic              trace_ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_e;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int PW  = $clog2(TRACE_DEPTH);
  localparam int FW  = PW + 1;

  state_e             state_q, state_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               ovf_q, ovf_d;
  logic               first_q, first_d;
  logic [ADDR_W-1:0]  last_pc_q, last_pc_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               cpu_start_q, cpu_start_d;
  logic               cpu_enable_q, cpu_enable_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [ADDR_W-1:0]  head_q, head_d;
  logic [ADDR_W-1:0]  mem [TRACE_DEPTH];

  logic clear, push, push_ok, pop_ok, run_en, is_halt, step_ok;

  assign is_halt = (cpu_id_ir_i[DATA_W-1 -: 5] == HALT_OPCODE);
  // Registered enable doubles as the qualifier for counting, tracing and exit checks.
  assign run_en  = (state_q == S_RUN) && cpu_enable_q;

`ifdef RUN_CTRL_STEP_EN
  logic step_q;
  assign step_ok = !step_mode_i || (step_i && !step_q);

  always_ff @(posedge clock_i) begin
    if (reset_i) step_q <= 1'b0;
    else         step_q <= step_i;
  end
`else
  assign step_ok = 1'b1;
`endif

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    first_d   = first_q;
    last_pc_d = last_pc_q;
    clear     = 1'b0;
    push      = 1'b0;
    case (state_q)
      S_IDLE, S_STOP: begin
        if (go_i) begin
          state_d   = S_RST;
          rst_cnt_d = '0;
          cnt_d     = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          clear     = 1'b1;
        end
      end
      S_RST: begin
        if (abort_i) begin
          state_d = S_STOP;
        end else if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
          first_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_RUN: begin
        if (run_en) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          if (first_q || (cpu_pc_i != last_pc_q)) begin
            push      = 1'b1;
            last_pc_d = cpu_pc_i;
          end
          first_d = 1'b0;
        end
        if (abort_i) begin
          state_d = S_STOP;
        end else if (run_en && is_halt) begin
          state_d = S_STOP;
          done_d  = 1'b1;
        end else if (run_en && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d   = S_STOP;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_reset_d  = (state_d == S_IDLE) || (state_d == S_RST);
    cpu_start_d  = (state_d == S_RUN);
    cpu_enable_d = (state_d == S_RUN) && step_ok;
  end

  always_comb begin
    pop_ok   = trace_rd_i && (fill_q != '0);
    push_ok  = push && ((fill_q != FW'(TRACE_DEPTH)) || pop_ok);
    ovf_d    = ovf_q || (push && !push_ok);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    fill_d   = fill_q + FW'(push_ok) - FW'(pop_ok);
    if (clear) begin
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end
    // Head is registered; bypass the write when the new entry lands at the next read slot.
    if (fill_d == '0)                           head_d = '0;
    else if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = cpu_pc_i;
    else                                        head_d = mem[rd_ptr_d];
  end

  // NOTE: trace storage has no reset; validity is tracked by fill_q alone.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem[wr_ptr_q] <= cpu_pc_i;
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      ovf_q        <= 1'b0;
      first_q      <= 1'b0;
      last_pc_q    <= '0;
      cpu_reset_q  <= 1'b1;
      cpu_start_q  <= 1'b0;
      cpu_enable_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      head_q       <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      ovf_q        <= ovf_d;
      first_q      <= first_d;
      last_pc_q    <= last_pc_d;
      cpu_reset_q  <= cpu_reset_d;
      cpu_start_q  <= cpu_start_d;
      cpu_enable_q <= cpu_enable_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      head_q       <= head_d;
    end
  end

  assign state_o       = state_q;
  assign cpu_reset_o   = cpu_reset_q;
  assign cpu_start_o   = cpu_start_q;
  assign cpu_enable_o  = cpu_enable_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign cycle_cnt_o   = cnt_q;
  assign trace_data_o  = head_q;
  assign trace_valid_o = (fill_q != '0);
  assign trace_ovf_o   = ovf_q;

endmodule
